imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate extender: packs a 32-bit immediate into the RISC-V
//  I/S/B/J instruction fields instr[31:7]. Non-immediate fields come from a base word.
//  Sits in the assembler/test-generation path. It checks range and alignment,
//  buffers results in a small FIFO and uses valid/ready handshakes on both sides.
// PARAMETERS
//  DEPTH  2  output FIFO entries; power of 2, >=2
//  ERR_W  8  width of the saturating error counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid && in_ready
//  imm        in   32     immediate value (two's complement)
//  immsrc     in   2      00 I, 01 S, 10 B, 11 J (same code as the extender)
//  base       in   25     instr[31:7] template; supplies the non-immediate fields
//  out_valid  out  1      FIFO head valid
//  out_ready  in   1      consumer pops when out_valid && out_ready
//  instr      out  25     encoded instr[31:7] at FIFO head
//  out_err    out  1      head entry failed the range/alignment check
//  err_count  out  ERR_W  number of accepted requests that had an error; saturates at all-ones
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - FIFO emptied; out_valid=0, instr=0, out_err=0, err_count=0, in_ready=1.
//   - An in-flight handshake in that cycle is discarded.
//  Encode (combinational, applied at accept). b = base:
//   - I: {imm[11:0], b[19:7]}
//   - S: {imm[11:5], b[24:12], imm[4:0]}
//   - B: {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11]}
//   - J: {imm[20], imm[10:1], imm[11], imm[19:12], b[11:7]}
//  Error rules:
//   - I/S: err unless imm[31:11] are all equal.
//   - B: err unless imm[31:12] are all equal and imm[0]=0.
//   - J: err unless imm[31:20] are all equal and imm[0]=0.
//   - An erroring entry is still encoded (truncated bits) and still enqueued.
//  Handshake and FIFO:
//   - in_ready = !full. Accept writes {instr, err}.
//   - Latency: an entry accepted at edge N is visible on out_valid/instr at edge N+1.
//   - out_valid = !empty; instr/out_err show the head entry and hold while out_ready=0.
//   - Push and pop in the same cycle: occupancy unchanged and order preserved.
//     When full, no push occurs (in_ready=0); a pop in that cycle frees one slot
//     from the next cycle.
//   - Pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
//   - When empty, instr and out_err are don't-care to the consumer; the bench checks
//     them only when out_valid=1.
//  err_count increments on each accepted erroring request and holds at 2^ERR_W-1.
// TESTING
//  1. I, imm=32'hFFFFFFFF, base=0 -> next cycle instr=25'h1FFE000, out_err=0.
//  2. B, imm=32'hFFFFF800, base=0 -> instr[24]=1, instr[0]=1, other bits 0, out_err=0.
//  3. J, imm=32'h00000801 -> out_err=1, err_count=1. I, imm=32'h00000800 -> out_err=1, err_count=2.
//  4. DEPTH=2, out_ready=0, three back-to-back requests -> in_ready=0 after the second;
//     then out_ready=1 -> three entries pop in order, with no loss or duplication.
//  5. Assert reset_n=0 with 2 entries queued and in_valid=1 -> next cycle out_valid=0,
//     in_ready=1, err_count=0.
//  6. Random legal imm/immsrc, out_ready toggling -> passing instr through the immediate
//     extender returns imm exactly and out_err=0 throughout.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into RISC-V I/S/B/J fields of instr[31:7], flags
// out-of-range or misaligned immediates, and queues results in a small FIFO.
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      imm,
    input  logic [1:0]       immsrc,
    input  logic [24:0]      base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      instr,
    output logic             out_err,
    output logic [ERR_W-1:0] err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [24:0] instr;
        logic        err;
    } entry_t;

    entry_t          enc;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    // base[k] holds instr bit k+7, so instr[19:7] is base[12:0], etc.
    always_comb begin
        enc = '0;
        case (immsrc)
            2'b00: begin
                enc.instr = {imm[11:0], base[12:0]};
                enc.err   = !(&imm[31:11] || ~|imm[31:11]);
            end
            2'b01: begin
                enc.instr = {imm[11:5], base[17:5], imm[4:0]};
                enc.err   = !(&imm[31:11] || ~|imm[31:11]);
            end
            2'b10: begin
                enc.instr = {imm[12], imm[10:5], base[17:5], imm[4:1], imm[11]};
                enc.err   = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
            end
            default: begin
                enc.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[4:0]};
                enc.err   = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
            end
        endcase
    end

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Mask the head while empty so reset shows instr=0 without clearing storage.
    assign instr   = out_valid ? mem[rd_ptr].instr : '0;
    assign out_err = out_valid ? mem[rd_ptr].err   : 1'b0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && enc.err && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder: encodings, error flags,
// backpressure ordering, reset flush, and round-trip through an extender model.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] imm;
    logic [1:0]  immsrc;
    logic [24:0] base;
    logic        out_valid, out_ready;
    logic [24:0] instr;
    logic        out_err;
    logic [7:0]  err_count;

    int nvec = 0;
    int nerr = 0;

    imm_encoder #(.DEPTH(2), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .immsrc(immsrc), .base(base),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate extender: reconstructs imm from instr[31:7].
    function automatic logic [31:0] extend(input logic [24:0] i, input logic [1:0] s);
        case (s)
            2'b00:   return {{20{i[24]}}, i[24:13]};
            2'b01:   return {{20{i[24]}}, i[24:18], i[4:0]};
            2'b10:   return {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            default: return {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
        endcase
    endfunction

    task automatic send(input logic [1:0] s, input logic [31:0] v, input logic [24:0] b);
        immsrc = s; imm = v; base = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain1();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [24:0] popped [3];
        logic [31:0] qimm [$];
        logic [1:0]  qsrc [$];
        logic [31:0] r;
        int got, sent, cyc;
        logic acc;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm = '0; immsrc = '0; base = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_rdy", in_ready, 1);
        reset_n = 1'b1;

        // I, all-ones immediate
        out_ready = 1'b1;
        send(2'b00, 32'hFFFF_FFFF, 25'h0);
        chk("i_valid", out_valid, 1);
        chk("i_instr", instr, 25'h1FF_E000);
        chk("i_err", out_err, 0);
        drain1();
        chk("i_drained", out_valid, 0);

        // B, imm=-2048
        send(2'b10, 32'hFFFF_F800, 25'h0);
        chk("b_instr", instr, 25'h100_0001);
        chk("b_err", out_err, 0);
        drain1();

        // S with base fields preserved
        send(2'b01, 32'h0000_0123, 25'h1FF_FFFF);
        chk("s_instr", instr, 25'h027_FFE3);
        chk("s_err", out_err, 0);
        drain1();

        // J, imm=0 keeps rd from base
        send(2'b11, 32'h0, 25'h1FF_FFFF);
        chk("j_instr", instr, 25'h1F);
        drain1();

        // error cases
        send(2'b11, 32'h0000_0801, 25'h0);
        chk("j_odd_err", out_err, 1);
        chk("j_odd_cnt", err_count, 1);
        drain1();
        send(2'b00, 32'h0000_0800, 25'h0);
        chk("i_rng_err", out_err, 1);
        chk("i_rng_cnt", err_count, 2);
        drain1();

        // backpressure: three requests into a two-deep FIFO
        out_ready = 1'b0;
        send(2'b00, 32'd1, 25'h0);
        chk("bp_rdy1", in_ready, 1);
        send(2'b00, 32'd2, 25'h0);
        chk("bp_rdy2", in_ready, 0);
        chk("bp_head", instr, 25'h2000);
        immsrc = 2'b00; imm = 32'd3; base = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_stall", in_ready, 0);
        chk("bp_hold", instr, 25'h2000);
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 3 && cyc < 20) begin
            if (out_valid) begin
                popped[got] = instr;
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", got, 3);
        chk("bp_pop0", popped[0], 25'h2000);
        chk("bp_pop1", popped[1], 25'h4000);
        chk("bp_pop2", popped[2], 25'h6000);
        chk("bp_empty", out_valid, 0);

        // reset with two entries queued and a request pending
        out_ready = 1'b0;
        send(2'b00, 32'd5, 25'h0);
        send(2'b11, 32'd1, 25'h0);
        chk("rq_full", in_ready, 0);
        chk("rq_cnt", err_count, 3);
        in_valid = 1'b1; reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rq_valid", out_valid, 0);
        chk("rq_rdy", in_ready, 1);
        chk("rq_cnt0", err_count, 0);
        in_valid = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rq_stay_empty", out_valid, 0);

        // random legal immediates, round-trip through the extender
        sent = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            if (!in_valid && sent < 40) begin
                immsrc = 2'($urandom_range(0, 3));
                r = $urandom;
                case (immsrc)
                    2'b00, 2'b01: imm = {{20{r[11]}}, r[11:0]};
                    2'b10:        imm = {{19{r[12]}}, r[12:1], 1'b0};
                    default:      imm = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                base = 25'($urandom);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (qimm.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    chk("rnd_imm", extend(instr, qsrc[0]), qimm[0]);
                    chk("rnd_err", out_err, 0);
                    void'(qimm.pop_front());
                    void'(qsrc.pop_front());
                end
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                qimm.push_back(imm);
                qsrc.push_back(immsrc);
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rnd_done", got, 40);
        chk("rnd_errcnt", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
